// File: rtl/controlador_rega.sv
// controlador_rega: irrigation decision FSM feeding the irrigation-type 7-segment driver.
// Optional macro CONTROLE_NIVEL_EN enables the reservoir-low sensor and the ALARME state.
module controlador_rega #(
   parameter int PRESCALE      = 50000000,
   parameter int T_ASPERSAO    = 30,
   parameter int T_GOTEJAMENTO = 90,
   parameter int T_PAUSA       = 20,
   parameter int W_TEMPO       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               habilitar,
   input  logic [1:0]         umidade,
   input  logic               chuva,
   input  logic               nivel_baixo,
   output logic               aspersao,
   output logic               gotejamento,
   output logic               valvula,
   output logic               alarme,
   output logic [W_TEMPO-1:0] tempo_restante
);

   localparam int                 PS_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]    PS_MAX  = PS_W'(PRESCALE - 1);
   localparam logic [W_TEMPO-1:0] LD_ASP  = W_TEMPO'(T_ASPERSAO);
   localparam logic [W_TEMPO-1:0] LD_GOT  = W_TEMPO'(T_GOTEJAMENTO);
   localparam logic [W_TEMPO-1:0] LD_PAU  = W_TEMPO'(T_PAUSA);
   localparam logic [W_TEMPO-1:0] TMR_ONE = W_TEMPO'(1);

   typedef enum logic [2:0] {
      ST_OCIOSO      = 3'd0,
      ST_AVALIA      = 3'd1,
      ST_ASPERSAO    = 3'd2,
      ST_GOTEJAMENTO = 3'd3,
      ST_PAUSA       = 3'd4
`ifdef CONTROLE_NIVEL_EN
      , ST_ALARME    = 3'd5
`endif
   } estado_t;

   function automatic logic temporizado(input estado_t e);
      return (e == ST_ASPERSAO) || (e == ST_GOTEJAMENTO) || (e == ST_PAUSA);
   endfunction

   logic               r_hab_s1, r_hab_s2;
   logic [1:0]         r_umi_s1, r_umi_s2;
   logic               r_chuva_s1, r_chuva_s2;
`ifdef CONTROLE_NIVEL_EN
   logic               r_nivel_s1, r_nivel_s2;
   logic               r_alarme;
`else
   logic               w_unused_nivel;
`endif

   estado_t            r_estado, w_prox;
   logic [PS_W-1:0]    r_presc;
   logic [W_TEMPO-1:0] r_timer;
   logic               r_aspersao, r_gotejamento, r_valvula;

   logic               w_tick, w_expira, w_entra;
   logic [W_TEMPO-1:0] w_carga;

   assign w_tick   = (r_presc == PS_MAX);
   assign w_expira = w_tick && (r_timer == TMR_ONE);
   assign w_entra  = temporizado(w_prox) && (w_prox != r_estado);

   // Next-state decision: every branch uses only synchronized inputs,
   // and within each state the checks are ordered by priority.
   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         ST_OCIOSO: begin
            if (r_hab_s2) w_prox = ST_AVALIA;
         end
         ST_AVALIA: begin
            if (!r_hab_s2)                      w_prox = ST_OCIOSO;
`ifdef CONTROLE_NIVEL_EN
            else if (r_nivel_s2)                w_prox = ST_ALARME;
`endif
            else if (r_chuva_s2 || r_umi_s2[1]) w_prox = ST_OCIOSO;
            else if (r_umi_s2 == 2'b00)         w_prox = ST_ASPERSAO;
            else                                w_prox = ST_GOTEJAMENTO;
         end
         ST_ASPERSAO, ST_GOTEJAMENTO: begin
            if (!r_hab_s2)                                   w_prox = ST_OCIOSO;
`ifdef CONTROLE_NIVEL_EN
            else if (r_nivel_s2)                             w_prox = ST_ALARME;
`endif
            else if (r_chuva_s2 || (r_umi_s2 == 2'b11))      w_prox = ST_PAUSA;
            else if (w_expira)                               w_prox = ST_PAUSA;
         end
         ST_PAUSA: begin
            if (!r_hab_s2)     w_prox = ST_OCIOSO;
            else if (w_expira) w_prox = ST_AVALIA;
         end
`ifdef CONTROLE_NIVEL_EN
         ST_ALARME: begin
            // Leaving requires the operator to disable after the reservoir refills.
            if (!r_nivel_s2 && !r_hab_s2) w_prox = ST_OCIOSO;
         end
`endif
         default: w_prox = ST_OCIOSO;
      endcase
   end

   always_comb begin
      w_carga = '0;
      case (w_prox)
         ST_ASPERSAO:    w_carga = LD_ASP;
         ST_GOTEJAMENTO: w_carga = LD_GOT;
         ST_PAUSA:       w_carga = LD_PAU;
         default:        w_carga = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hab_s1      <= 1'b0;
         r_hab_s2      <= 1'b0;
         r_umi_s1      <= 2'b00;
         r_umi_s2      <= 2'b00;
         r_chuva_s1    <= 1'b0;
         r_chuva_s2    <= 1'b0;
`ifdef CONTROLE_NIVEL_EN
         r_nivel_s1    <= 1'b0;
         r_nivel_s2    <= 1'b0;
         r_alarme      <= 1'b0;
`endif
         r_estado      <= ST_OCIOSO;
         r_presc       <= '0;
         r_timer       <= '0;
         r_aspersao    <= 1'b0;
         r_gotejamento <= 1'b0;
         r_valvula     <= 1'b0;
      end else begin
         r_hab_s1      <= habilitar;
         r_hab_s2      <= r_hab_s1;
         r_umi_s1      <= umidade;
         r_umi_s2      <= r_umi_s1;
         r_chuva_s1    <= chuva;
         r_chuva_s2    <= r_chuva_s1;
`ifdef CONTROLE_NIVEL_EN
         r_nivel_s1    <= nivel_baixo;
         r_nivel_s2    <= r_nivel_s1;
         r_alarme      <= (w_prox == ST_ALARME);
`endif
         r_estado      <= w_prox;

         // Restarting the prescaler on entry makes each timed state exactly T*PRESCALE cycles.
         if (w_entra || w_tick) r_presc <= '0;
         else                   r_presc <= r_presc + PS_W'(1);

         if (w_entra)                   r_timer <= w_carga;
         else if (!temporizado(w_prox)) r_timer <= '0;
         else if (w_tick)               r_timer <= r_timer - TMR_ONE;

         r_aspersao    <= (w_prox == ST_ASPERSAO);
         r_gotejamento <= (w_prox == ST_GOTEJAMENTO);
         r_valvula     <= (w_prox == ST_ASPERSAO) || (w_prox == ST_GOTEJAMENTO);
      end
   end

`ifdef CONTROLE_NIVEL_EN
   assign alarme = r_alarme;
`else
   assign w_unused_nivel = nivel_baixo;
   assign alarme         = 1'b0;
`endif

   assign aspersao       = r_aspersao;
   assign gotejamento    = r_gotejamento;
   assign valvula        = r_valvula;
   assign tempo_restante = r_timer;

endmodule

// File: tb/tb_controlador_rega.sv
// Self-checking bench for controlador_rega: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a phase/remaining-cycles model.
module tb_controlador_rega;

   localparam int P  = 4;
   localparam int TA = 3;
   localparam int TG = 5;
   localparam int TP = 2;
   localparam int W  = 8;

   localparam int M_IDLE   = 0;
   localparam int M_EVAL   = 1;
   localparam int M_SPRINK = 2;
   localparam int M_DRIP   = 3;
   localparam int M_COOL   = 4;
   localparam int M_ALARM  = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         habilitar = 1'b0;
   logic [1:0]   umidade = 2'b00;
   logic         chuva = 1'b0;
   logic         nivel_baixo = 1'b0;
   logic         aspersao, gotejamento, valvula, alarme;
   logic [W-1:0] tempo_restante;

   always #5 clk = ~clk;

   controlador_rega #(
      .PRESCALE(P), .T_ASPERSAO(TA), .T_GOTEJAMENTO(TG), .T_PAUSA(TP), .W_TEMPO(W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .habilitar(habilitar), .umidade(umidade),
      .chuva(chuva), .nivel_baixo(nivel_baixo), .aspersao(aspersao),
      .gotejamento(gotejamento), .valvula(valvula), .alarme(alarme),
      .tempo_restante(tempo_restante)
   );

   typedef struct packed {
      int mode;
      int rem;   // cycles left in the current timed phase
   } mstate_t;

   function automatic logic timed(input int m);
      return (m == M_SPRINK) || (m == M_DRIP) || (m == M_COOL);
   endfunction

   // One clock of the reference: in = {hab, umidade, chuva, nivel} as seen after synchronization.
   function automatic mstate_t model_step(input mstate_t s, input logic [4:0] in);
      mstate_t    n;
      logic       hab, ch, nb, done;
      logic [1:0] um;
      hab = in[4];
      um  = in[3:2];
      ch  = in[1];
`ifdef CONTROLE_NIVEL_EN
      nb  = in[0];
`else
      nb  = 1'b0;
`endif
      n    = s;
      done = (s.rem == 1);
      if (timed(s.mode)) n.rem = s.rem - 1;
      case (s.mode)
         M_IDLE: if (hab) n.mode = M_EVAL;
         M_EVAL: begin
            if (!hab)                 n.mode = M_IDLE;
            else if (nb)              n.mode = M_ALARM;
            else if (ch || um >= 2)   n.mode = M_IDLE;
            else if (um == 0) begin   n.mode = M_SPRINK; n.rem = TA * P; end
            else begin                n.mode = M_DRIP;   n.rem = TG * P; end
         end
         M_SPRINK, M_DRIP: begin
            if (!hab)      n.mode = M_IDLE;
            else if (nb)   n.mode = M_ALARM;
            else if (ch || um == 3 || done) begin n.mode = M_COOL; n.rem = TP * P; end
         end
         M_COOL: begin
            if (!hab)      n.mode = M_IDLE;
            else if (done) n.mode = M_EVAL;
         end
         M_ALARM: if (!nb && !hab) n.mode = M_IDLE;
         default: n.mode = M_IDLE;
      endcase
      if (!timed(n.mode)) n.rem = 0;
      return n;
   endfunction

   function automatic logic [11:0] lv(input logic a, input logic g, input logic v,
                                       input logic al, input int t);
      return {a, g, v, al, 8'(t)};
   endfunction

   function automatic logic [11:0] exp_vec(input mstate_t s);
      logic a, g;
      int   t;
      a = (s.mode == M_SPRINK);
      g = (s.mode == M_DRIP);
      t = timed(s.mode) ? (s.rem + P - 1) / P : 0;
      return lv(a, g, a | g, s.mode == M_ALARM, t);
   endfunction

   // Reference model: inputs reach the decision two clocks after being sampled.
   mstate_t    m_st = '{M_IDLE, 0};
   logic       m_valid = 1'b0;
   logic [4:0] hist [4];
   int         cyc = 0;
   int         last_rst = 0;
   logic [1:0] w_idx_now, w_idx_old;
   logic [4:0] w_seen;
   logic [11:0] w_act, w_exp;

   assign w_idx_now = cyc[1:0];
   assign w_idx_old = w_idx_now - 2'd2;
   assign w_seen    = (cyc - 2 > last_rst) ? hist[w_idx_old] : 5'd0;
   assign w_act     = {aspersao, gotejamento, valvula, alarme, tempo_restante};
   assign w_exp     = exp_vec(m_st);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      hist[w_idx_now] <= {habilitar, umidade, chuva, nivel_baixo};
      if (!rst_n) begin
         m_st     <= '{M_IDLE, 0};
         last_rst <= cyc;
         m_valid  <= 1'b1;
      end else begin
         m_st <= model_step(m_st, w_seen);
      end
   end

   // Single compare process: model check every cycle, plus pending literal checks.
   int          checks = 0;
   int          errors = 0;
   int          lit_req = 0;
   int          lit_done = 0;
   logic [11:0] lit_exp = '0;
   string       lit_name = "";

   always @(negedge clk) begin
      if (m_valid) begin
         if (w_act !== w_exp)
            $display("FAIL model cyc=%0d act=%h exp=%h", cyc, w_act, w_exp);
         if (lit_req != lit_done) begin
            if (w_act !== lit_exp)
               $display("FAIL %s act=%h exp=%h", lit_name, w_act, lit_exp);
            lit_done <= lit_req;
         end
         checks <= checks + 1 + ((lit_req != lit_done) ? 1 : 0);
         errors <= errors + ((w_act !== w_exp) ? 1 : 0)
                          + (((lit_req != lit_done) && (w_act !== lit_exp)) ? 1 : 0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [11:0] e);
      lit_name = name;
      lit_exp  = e;
      lit_req  = lit_req + 1;
      @(negedge clk);
      #1;
   endtask

   task automatic go_idle();
      habilitar   = 1'b0;
      umidade     = 2'b00;
      chuva       = 1'b0;
      nivel_baixo = 1'b0;
      step(4);
   endtask

   initial begin
      step(3);
      rst_n = 1'b1;
      chk("reset", '0);

      // Dry soil: sprinkler from edge 4, 12 cycles, then 8-cycle pause, then again.
      habilitar = 1'b1;
      umidade   = 2'b00;
      step(3); chk("dry_eval", '0);
      step(1); chk("dry_asp_start", lv(1, 0, 1, 0, 3));
      step(4); chk("dry_t2", lv(1, 0, 1, 0, 2));
      step(7); chk("dry_t1", lv(1, 0, 1, 0, 1));
      step(1); chk("dry_pausa", lv(0, 0, 0, 0, 2));
      step(8); chk("dry_avalia", '0);
      step(1); chk("dry_rerun", lv(1, 0, 1, 0, 3));

      // Rain 5 cycles into sprinkling.
      step(5);
      chuva = 1'b1;
      step(2); chk("rain_pre", lv(1, 0, 1, 0, 2));
      step(1); chk("rain_abort", lv(0, 0, 0, 0, 2));
      step(9); chk("rain_idle", '0);

      // Low moisture, then reservoir low during drip.
      go_idle();
      habilitar = 1'b1;
      umidade   = 2'b01;
      step(4); chk("drip_start", lv(0, 1, 1, 0, 5));
      step(3);
      nivel_baixo = 1'b1;
      step(2); chk("drip_pre_alarm", lv(0, 1, 1, 0, 4));
`ifdef CONTROLE_NIVEL_EN
      step(1); chk("alarm_on", lv(0, 0, 0, 1, 0));
      nivel_baixo = 1'b0;
      step(4); chk("alarm_hold", lv(0, 0, 0, 1, 0));
`else
      step(1); chk("alarm_off", lv(0, 1, 1, 0, 4));
      nivel_baixo = 1'b0;
      step(4); chk("alarm_off_hold", lv(0, 1, 1, 0, 3));
`endif
      habilitar = 1'b0;
      step(3); chk("alarm_ack", '0);

      // Disable and reservoir-low arriving together with sprinkler expiry.
      go_idle();
      habilitar = 1'b1;
      step(13);
      habilitar   = 1'b0;
      nivel_baixo = 1'b1;
      step(2); chk("prio_pre", lv(1, 0, 1, 0, 1));
      step(1); chk("prio_expiry", '0);
      nivel_baixo = 1'b0;

      // Reset in the middle of sprinkling.
      go_idle();
      habilitar = 1'b1;
      step(6); chk("rst_pre", lv(1, 0, 1, 0, 3));
      rst_n = 1'b0;
      step(1); chk("rst_mid", '0);
      rst_n = 1'b1;

      // Saturation mid-sprinkle, then ok moisture at evaluation.
      go_idle();
      habilitar = 1'b1;
      step(6);
      umidade = 2'b11;
      step(2); chk("sat_pre", lv(1, 0, 1, 0, 2));
      step(1); chk("sat_abort", lv(0, 0, 0, 0, 2));
      step(9); chk("sat_idle", '0);
      go_idle();
      habilitar = 1'b1;
      umidade   = 2'b10;
      step(8); chk("ok_moist_idle", '0);

      // Randomized traffic, checked by the model each cycle.
      go_idle();
      habilitar = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         step(1);
         if ($urandom_range(0, 999) < 15)  habilitar   = ~habilitar;
         if ($urandom_range(0, 99)  < 4)   umidade     = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 999) < 25)  chuva       = ~chuva;
         if ($urandom_range(0, 999) < 12)  nivel_baixo = ~nivel_baixo;
         rst_n = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      end
      rst_n = 1'b1;
      step(2);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
